// File: rtl/axil_apb_bridge.sv
// rtl/axil_apb_bridge.sv - AXI4-Lite to APB bridge, one transfer at a time; optional AXIL_APB_TIMEOUT_EN access timeout
module axil_apb_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    // AXI-Lite write address
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    // AXI-Lite write data
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    // AXI-Lite write response
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    // AXI-Lite read address
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    // AXI-Lite read data
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    // APB master
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [2:0]                pprot,
    output logic                      pwrite,
    output logic [NUM_SLAVES-1:0]     psel,
    output logic                      penable,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                  state_q, state_d;

    // one-entry holding registers for AW, W and AR
    logic                    aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic [2:0]              aw_prot_q, aw_prot_d;
    logic                    w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]       w_strb_q, w_strb_d;
    logic                    ar_full_q, ar_full_d;
    logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
    logic [2:0]              ar_prot_q, ar_prot_d;

    // rr_write_q set means the write side wins the next read/write tie
    logic                    rr_write_q, rr_write_d;
    logic                    is_write_q, is_write_d;

    // registered outputs
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    pwrite_q, pwrite_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    write_pend;
    logic                    read_pend;
    logic                    grant_write;
    logic [IDX_W-1:0]        sel_idx;
    logic                    tmo_hit;

`ifdef AXIL_APB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // ready is the empty flag of each holding register, held low while in reset
    assign awready = rst & ~aw_full_q;
    assign wready  = rst & ~w_full_q;
    assign arready = rst & ~ar_full_q;

    assign paddr   = paddr_q;
    assign pprot   = pprot_q;
    assign pwrite  = pwrite_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwdata  = pwdata_q;
    assign pstrb   = pstrb_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;
    assign rresp   = rresp_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;

    // next-state logic: channel capture, arbitration and the APB phase sequencer
    always_comb begin
        state_d     = state_q;
        aw_full_d   = aw_full_q;
        aw_addr_d   = aw_addr_q;
        aw_prot_d   = aw_prot_q;
        w_full_d    = w_full_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        ar_full_d   = ar_full_q;
        ar_addr_d   = ar_addr_q;
        ar_prot_d   = ar_prot_q;
        rr_write_d  = rr_write_q;
        is_write_d  = is_write_q;
        paddr_d     = paddr_q;
        pprot_d     = pprot_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        bresp_d     = bresp_q;
        bvalid_d    = bvalid_q;
        rresp_d     = rresp_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        sel_idx     = '0;
`ifdef AXIL_APB_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif

        if (awvalid && awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
            aw_prot_d = awprot;
        end
        if (wvalid && wready) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (arvalid && arready) begin
            ar_full_d = 1'b1;
            ar_addr_d = araddr;
            ar_prot_d = arprot;
        end

        // a write needs both halves; a lone AW or W never starts a transfer
        write_pend  = aw_full_q & w_full_q;
        read_pend   = ar_full_q;
        grant_write = write_pend & (~read_pend | rr_write_q);

        case (state_q)
            ST_IDLE: begin
                if (read_pend || write_pend) begin
                    state_d    = ST_SETUP;
                    is_write_d = grant_write;
                    pwrite_d   = grant_write;
                    if (read_pend && write_pend) begin
                        rr_write_d = ~grant_write;
                    end
                    if (grant_write) begin
                        paddr_d  = aw_addr_q;
                        pprot_d  = aw_prot_q;
                        pwdata_d = w_data_q;
                        pstrb_d  = w_strb_q;
                    end else begin
                        paddr_d  = ar_addr_q;
                        pprot_d  = ar_prot_q;
                        pwdata_d = '0;
                        pstrb_d  = '0;
                    end
                    if (NUM_SLAVES > 1) begin
                        sel_idx = paddr_d[ADDR_WIDTH-1 -: IDX_W];
                    end
                    psel_d          = '0;
                    psel_d[sel_idx] = 1'b1;
                end
            end
            ST_SETUP: begin
                // pready is deliberately not looked at here
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (pready || tmo_hit) begin
                    state_d   = ST_RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (is_write_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = (pslverr || !pready) ? 2'b10 : 2'b00;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = (pslverr || !pready) ? 2'b10 : 2'b00;
                        rdata_d  = pready ? prdata : '0;
                    end
                end else begin
`ifdef AXIL_APB_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                // the holding registers are released only once the response is taken
                if (is_write_q && bready) begin
                    state_d   = ST_IDLE;
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end else if (!is_write_q && rready) begin
                    state_d   = ST_IDLE;
                    rvalid_d  = 1'b0;
                    ar_full_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and registered outputs; reset drops psel/penable at once and abandons the transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            aw_prot_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ar_full_q  <= 1'b0;
            ar_addr_q  <= '0;
            ar_prot_q  <= '0;
            rr_write_q <= 1'b0;
            is_write_q <= 1'b0;
            paddr_q    <= '0;
            pprot_q    <= '0;
            pwrite_q   <= 1'b0;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            bresp_q    <= '0;
            bvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
`ifdef AXIL_APB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            aw_prot_q  <= aw_prot_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            ar_full_q  <= ar_full_d;
            ar_addr_q  <= ar_addr_d;
            ar_prot_q  <= ar_prot_d;
            rr_write_q <= rr_write_d;
            is_write_q <= is_write_d;
            paddr_q    <= paddr_d;
            pprot_q    <= pprot_d;
            pwrite_q   <= pwrite_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            bresp_q    <= bresp_d;
            bvalid_q   <= bvalid_d;
            rresp_q    <= rresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
`ifdef AXIL_APB_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_axil_apb_bridge.sv
// tb/tb_axil_apb_bridge.sv - scoreboard bench for axil_apb_bridge
module tb_axil_apb_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [3:0]  psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    axil_apb_bridge #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .NUM_SLAVES    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .paddr   (paddr),
        .pprot   (pprot),
        .pwrite  (pwrite),
        .psel    (psel),
        .penable (penable),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    typedef struct {
        logic [3:0]  psel;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
    } apb_t;

    typedef struct {
        logic        is_write;
        logic [1:0]  resp;
        logic [31:0] data;
    } resp_t;

    apb_t  sb_apb[$];
    resp_t sb_resp[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int resp_seen = 0;
    int pen_cnt   = 0;

    int          slv_waits = 0;
    logic        slv_stuck = 1'b0;
    logic        slv_err   = 1'b0;
    logic [31:0] slv_rdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_apb(input logic [3:0] s, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] b, input logic [2:0] p);
        apb_t e;
        e.psel = s; e.paddr = a; e.pwrite = w; e.pwdata = d; e.pstrb = b; e.pprot = p;
        sb_apb.push_back(e);
    endtask

    task automatic exp_resp(input logic w, input logic [1:0] r, input logic [31:0] d);
        resp_t e;
        e.is_write = w; e.resp = r; e.data = d;
        sb_resp.push_back(e);
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [2:0] p);
        awaddr = a; awprot = p; awvalid = 1'b1;
    endtask

    task automatic set_w(input logic [31:0] d, input logic [3:0] s);
        wdata = d; wstrb = s; wvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [2:0] p);
        araddr = a; arprot = p; arvalid = 1'b1;
    endtask

    // hold the valids across one rising edge, then drop them
    task automatic handshake();
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int k = 0;
        while (resp_seen < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("resp_wait", 64'(resp_seen >= target), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // APB slave: pready high outside ACCESS (must be ignored in SETUP), wait states in ACCESS
    initial begin
        int waits_left;
        waits_left = 0;
        pready  = 1'b1;
        prdata  = '0;
        pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (psel != 4'b0 && penable) begin
                if (slv_stuck) begin
                    pready = 1'b0; prdata = '0; pslverr = 1'b0;
                end else if (waits_left == 0) begin
                    pready = 1'b1; prdata = slv_rdata; pslverr = slv_err;
                end else begin
                    pready = 1'b0; prdata = '0; pslverr = 1'b0;
                    waits_left--;
                end
            end else begin
                pready = 1'b1; prdata = '0; pslverr = 1'b0;
                waits_left = slv_waits;
            end
        end
    end

    // monitor: compares every APB setup phase and every AXI response against the queues
    initial begin
        apb_t  e;
        apb_t  cur;
        resp_t r;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                if (psel != 4'b0 && !penable) begin
                    pen_cnt = 0;
                    if (sb_apb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL apb_unexpected: psel=0x%0h paddr=0x%0h, expected no transfer", psel, paddr);
                    end else begin
                        e = sb_apb.pop_front();
                        cur = e;
                        chk("apb_psel",   psel,   e.psel);
                        chk("apb_paddr",  paddr,  e.paddr);
                        chk("apb_pwrite", pwrite, e.pwrite);
                        chk("apb_pwdata", pwdata, e.pwdata);
                        chk("apb_pstrb",  pstrb,  e.pstrb);
                        chk("apb_pprot",  pprot,  e.pprot);
                    end
                end
                if (penable) begin
                    pen_cnt++;
                    chk("apb_hold_paddr",  paddr,  cur.paddr);
                    chk("apb_hold_psel",   psel,   cur.psel);
                    chk("apb_hold_pwdata", pwdata, cur.pwdata);
                end
                if ((bvalid && bready) || (rvalid && rready)) begin
                    if (sb_resp.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL resp_unexpected: bvalid=%0b rvalid=%0b, expected none", bvalid, rvalid);
                    end else begin
                        r = sb_resp.pop_front();
                        chk("resp_kind_b", bvalid, r.is_write);
                        chk("resp_kind_r", rvalid, !r.is_write);
                        if (r.is_write) begin
                            chk("bresp", bresp, r.resp);
                        end else begin
                            chk("rresp", rresp, r.resp);
                            chk("rdata", rdata, r.data);
                        end
                    end
                    resp_seen++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        rst = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_psel",    psel,    4'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_bvalid",  bvalid,  1'b0);
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_awready", awready, 1'b0);
        chk("rst_paddr",   paddr,   32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {awready, wready, arready}, 3'b111);

        // basic write with latency check
        slv_waits = 0;
        exp_apb(4'b0001, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000);
        exp_resp(1'b1, 2'b00, 32'h0);
        @(posedge clk);
        #1 set_aw(32'h0000_0010, 3'b000); set_w(32'hDEAD_BEEF, 4'hF);
        handshake();
        @(negedge clk); chk("lat_n1_psel",    psel,    4'b0000);
        @(negedge clk); chk("lat_n2_psel",    psel,    4'b0001);
                        chk("lat_n2_penable", penable, 1'b0);
        @(negedge clk); chk("lat_n3_penable", penable, 1'b1);
        @(negedge clk); chk("lat_n4_bvalid",  bvalid,  1'b1);
        wait_resp(1);
        chk("wr_pen_cnt", pen_cnt, 1);

        // read with three wait states
        slv_waits = 3; slv_rdata = 32'h1234_5678;
        exp_apb(4'b0100, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 3'b101);
        exp_resp(1'b0, 2'b00, 32'h1234_5678);
        @(posedge clk);
        #1 set_ar(32'h8000_0004, 3'b101);
        handshake();
        wait_resp(2);
        chk("rd_wait_pen_cnt", pen_cnt, 4);

        // write slave error
        slv_waits = 1; slv_err = 1'b1;
        exp_apb(4'b0010, 32'h4000_0008, 1'b1, 32'hA5A5_0F0F, 4'b0011, 3'b010);
        exp_resp(1'b1, 2'b10, 32'h0);
        @(posedge clk);
        #1 set_aw(32'h4000_0008, 3'b010); set_w(32'hA5A5_0F0F, 4'b0011);
        handshake();
        wait_resp(3);
        chk("wr_err_pen_cnt", pen_cnt, 2);

        // read slave error still returns the captured data
        slv_waits = 0; slv_rdata = 32'hCAFE_F00D;
        exp_apb(4'b1000, 32'hC000_00FC, 1'b0, 32'h0, 4'h0, 3'b000);
        exp_resp(1'b0, 2'b10, 32'hCAFE_F00D);
        @(posedge clk);
        #1 set_ar(32'hC000_00FC, 3'b000);
        handshake();
        wait_resp(4);
        slv_err = 1'b0;

        // AW alone must wait with no APB activity
        @(posedge clk);
        #1 set_aw(32'h0000_0020, 3'b001);
        handshake();
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (psel != 4'b0 || penable) saw = 1'b1;
        end
        chk("aw_only_no_apb", saw, 1'b0);
        chk("aw_only_ready", {awready, wready}, 2'b01);
        exp_apb(4'b0001, 32'h0000_0020, 1'b1, 32'h0BAD_F00D, 4'b1100, 3'b001);
        exp_resp(1'b1, 2'b00, 32'h0);
        @(posedge clk);
        #1 set_w(32'h0BAD_F00D, 4'b1100);
        handshake();
        wait_resp(5);

        // ties: read wins first after reset, then alternate
        do_reset();
        slv_rdata = 32'h55AA_55AA;
        exp_apb(4'b0001, 32'h0000_0200, 1'b0, 32'h0, 4'h0, 3'b000);
        exp_resp(1'b0, 2'b00, 32'h55AA_55AA);
        exp_apb(4'b0010, 32'h4000_0100, 1'b1, 32'h1111_1111, 4'hF, 3'b000);
        exp_resp(1'b1, 2'b00, 32'h0);
        set_aw(32'h4000_0100, 3'b000); set_w(32'h1111_1111, 4'hF); set_ar(32'h0000_0200, 3'b000);
        handshake();
        wait_resp(7);

        slv_rdata = 32'h66BB_66BB;
        exp_apb(4'b1000, 32'hC000_0010, 1'b1, 32'h2222_2222, 4'hF, 3'b000);
        exp_resp(1'b1, 2'b00, 32'h0);
        exp_apb(4'b0100, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 3'b000);
        exp_resp(1'b0, 2'b00, 32'h66BB_66BB);
        @(posedge clk);
        #1 set_aw(32'hC000_0010, 3'b000); set_w(32'h2222_2222, 4'hF); set_ar(32'h8000_0020, 3'b000);
        handshake();
        wait_resp(9);

        slv_rdata = 32'h77CC_77CC;
        exp_apb(4'b0010, 32'h4000_0040, 1'b0, 32'h0, 4'h0, 3'b000);
        exp_resp(1'b0, 2'b00, 32'h77CC_77CC);
        exp_apb(4'b0001, 32'h0000_0030, 1'b1, 32'h3333_3333, 4'hF, 3'b000);
        exp_resp(1'b1, 2'b00, 32'h0);
        @(posedge clk);
        #1 set_aw(32'h0000_0030, 3'b000); set_w(32'h3333_3333, 4'hF); set_ar(32'h4000_0040, 3'b000);
        handshake();
        wait_resp(11);

        // reset during the second ACCESS cycle
        slv_waits = 5;
        exp_apb(4'b0100, 32'h8000_0000, 1'b1, 32'h0000_0077, 4'hF, 3'b000);
        @(posedge clk);
        #1 set_aw(32'h8000_0000, 3'b000); set_w(32'h0000_0077, 4'hF);
        handshake();
        begin
            int k = 0;
            while (!penable && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("mid_access_reached", penable, 1'b1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_psel",    psel,    4'b0);
        chk("async_rst_penable", penable, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bvalid || rvalid || psel != 4'b0) saw = 1'b1;
        end
        chk("post_rst_quiet", saw, 1'b0);
        chk("post_rst_ready2", {awready, wready, arready}, 3'b111);

        // pready stuck low
        slv_waits = 0; slv_stuck = 1'b1;
        exp_apb(4'b0010, 32'h4000_0044, 1'b0, 32'h0, 4'h0, 3'b000);
`ifdef AXIL_APB_TIMEOUT_EN
        exp_resp(1'b0, 2'b10, 32'h0);
        @(posedge clk);
        #1 set_ar(32'h4000_0044, 3'b000);
        handshake();
        wait_resp(12);
        chk("tmo_pen_cnt", pen_cnt, 16);
        slv_stuck = 1'b0;
`else
        @(posedge clk);
        #1 set_ar(32'h4000_0044, 3'b000);
        handshake();
        repeat (100) @(negedge clk);
        chk("stuck_penable", penable, 1'b1);
        chk("stuck_rvalid",  rvalid,  1'b0);
        slv_stuck = 1'b0;
        do_reset();
        @(negedge clk);
`endif

        chk("sb_apb_empty",  sb_apb.size(),  0);
        chk("sb_resp_empty", sb_resp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
